// File: rtl/lfsr_seq_checker.sv
// Read-side checker for the 8-bit LFSR stream carried by the async FIFO harness.
// It drains the FIFO, locks onto the sequence and counts matching and mismatching words.
module lfsr_seq_checker #(
  parameter int RD_LATENCY  = 1,
  parameter int LOSS_THRESH = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk_rd,
  input  logic                 reset_async,
  input  logic                 i_enable,
  input  logic                 i_fifo_empty,
  output logic                 o_rd_en,
  input  logic [7:0]           iv_fifo_dout,
  input  logic                 i_clr_cnt,
  output logic                 o_locked,
  output logic                 o_error,
  output logic [CNT_WIDTH-1:0] ov_good_cnt,
  output logic [CNT_WIDTH-1:0] ov_err_cnt
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam logic [3:0] MISS_LAST = 4'(LOSS_THRESH - 1);

  function automatic logic [7:0] nxt(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[2]};
  endfunction

  state_e                state_q, state_d;
  logic [7:0]            exp_q, exp_d;
  logic                  sync_q, sync_d;
  logic [3:0]            miss_q, miss_d;
  logic [CNT_WIDTH-1:0]  good_q, good_d;
  logic [CNT_WIDTH-1:0]  errc_q, errc_d;
  logic                  error_q, error_d;
  logic                  locked_q, locked_d;
  logic                  match_s;
  logic                  v;

  assign o_rd_en = i_enable & ~i_fifo_empty & ~reset_async;

  // Delay the read strobe to the cycle the FIFO presents the word.
  generate
    if (RD_LATENCY == 0) begin : g_fwft
      assign v = o_rd_en;
    end else begin : g_pipe
      logic [RD_LATENCY-1:0] vld_q, vld_d;

      always_comb begin
        vld_d = (vld_q << 1) | RD_LATENCY'(o_rd_en);
      end

      always_ff @(posedge clk_rd or posedge reset_async) begin
        if (reset_async) begin
          vld_q <= '0;
        end else begin
          vld_q <= vld_d;
        end
      end

      assign v = vld_q[RD_LATENCY-1];
    end
  endgenerate

  // Sequence tracking, lock state machine and saturating counters.
  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    sync_d   = sync_q;
    miss_d   = miss_q;
    good_d   = good_q;
    errc_d   = errc_q;
    error_d  = 1'b0;
    match_s  = (iv_fifo_dout == exp_q);

    if (v) begin
      case (state_q)
        ST_SEARCH: begin
          exp_d   = nxt(iv_fifo_dout);
          sync_d  = 1'b0;
          state_d = ST_SYNC;
        end
        ST_SYNC: begin
          if (match_s) begin
            exp_d = nxt(exp_q);
            if (sync_q) begin
              state_d = ST_LOCKED;
              sync_d  = 1'b0;
            end else begin
              sync_d = 1'b1;
            end
          end else begin
            // Reseed from the received word until two predictions hold in a row.
            exp_d  = nxt(iv_fifo_dout);
            sync_d = 1'b0;
          end
        end
        ST_LOCKED: begin
          exp_d = nxt(exp_q);
          if (match_s) begin
            miss_d = 4'd0;
            if (good_q != '1) begin
              good_d = good_q + CNT_WIDTH'(1);
            end else begin
              good_d = good_q;
            end
          end else begin
            error_d = 1'b1;
            if (errc_q != '1) begin
              errc_d = errc_q + CNT_WIDTH'(1);
            end else begin
              errc_d = errc_q;
            end
            if (miss_q == MISS_LAST) begin
              state_d = ST_SEARCH;
              miss_d  = 4'd0;
            end else begin
              miss_d = miss_q + 4'd1;
            end
          end
        end
        default: begin
          state_d = ST_SEARCH;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (i_clr_cnt) begin
      good_d = '0;
      errc_d = '0;
    end else begin
      good_d = good_d;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // State and output registers.
  always_ff @(posedge clk_rd or posedge reset_async) begin
    if (reset_async) begin
      state_q  <= ST_SEARCH;
      exp_q    <= 8'd0;
      sync_q   <= 1'b0;
      miss_q   <= 4'd0;
      good_q   <= '0;
      errc_q   <= '0;
      error_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      sync_q   <= sync_d;
      miss_q   <= miss_d;
      good_q   <= good_d;
      errc_q   <= errc_d;
      error_q  <= error_d;
      locked_q <= locked_d;
    end
  end

  assign o_locked    = locked_q;
  assign o_error     = error_q;
  assign ov_good_cnt = good_q;
  assign ov_err_cnt  = errc_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed bench for lfsr_seq_checker: a queue-based FIFO model with one cycle of
// read latency feeds a 16-bit-counter instance and a 4-bit-counter instance in parallel.
module tb_lfsr_seq_checker;

  logic        clk_rd = 1'b0;
  logic        reset_async;
  logic        i_enable;
  logic        i_fifo_empty;
  logic        i_clr_cnt;
  logic [7:0]  iv_fifo_dout;
  logic        o_rd_en, o_locked, o_error;
  logic [15:0] good_cnt, err_cnt;
  logic        rd_en_w4, locked_w4, error_w4;
  logic [3:0]  good_w4, err_w4;

  int          checks = 0;
  int          failures = 0;
  int          err_pulses = 0;
  logic        force_empty = 1'b0;
  logic [7:0]  q[$];
  logic [7:0]  seq_w;

  always #5 clk_rd = ~clk_rd;

  lfsr_seq_checker #(.RD_LATENCY(1), .LOSS_THRESH(4), .CNT_WIDTH(16)) dut (
    .clk_rd(clk_rd), .reset_async(reset_async), .i_enable(i_enable),
    .i_fifo_empty(i_fifo_empty), .o_rd_en(o_rd_en), .iv_fifo_dout(iv_fifo_dout),
    .i_clr_cnt(i_clr_cnt), .o_locked(o_locked), .o_error(o_error),
    .ov_good_cnt(good_cnt), .ov_err_cnt(err_cnt)
  );

  lfsr_seq_checker #(.RD_LATENCY(1), .LOSS_THRESH(4), .CNT_WIDTH(4)) dut_w4 (
    .clk_rd(clk_rd), .reset_async(reset_async), .i_enable(i_enable),
    .i_fifo_empty(i_fifo_empty), .o_rd_en(rd_en_w4), .iv_fifo_dout(iv_fifo_dout),
    .i_clr_cnt(i_clr_cnt), .o_locked(locked_w4), .o_error(error_w4),
    .ov_good_cnt(good_w4), .ov_err_cnt(err_w4)
  );

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[2]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock: the FIFO model pops a word one cycle after a sampled read.
  task automatic step();
    logic rd;
    i_fifo_empty = force_empty || (q.size() == 0);
    #1 rd = o_rd_en;
    @(posedge clk_rd);
    #1;
    if (rd && !reset_async && q.size() != 0) iv_fifo_dout = q.pop_front();
    if (o_error) err_pulses++;
  endtask

  task automatic push_seq(input logic [7:0] seed, input int n);
    seq_w = seed;
    for (int i = 0; i < n; i++) begin
      q.push_back(seq_w);
      seq_w = lfsr_next(seq_w);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      step();
      n++;
    end
    check_eq("drain_done", q.size(), 0);
    repeat (3) step();
  endtask

  task automatic do_reset();
    reset_async = 1'b1;
    q.delete();
    q.push_back(8'hA5);
    step();
    step();
    reset_async = 1'b0;
    q.delete();
    err_pulses = 0;
  endtask

  initial begin
    reset_async  = 1'b1;
    i_enable     = 1'b1;
    i_clr_cnt    = 1'b0;
    iv_fifo_dout = 8'h00;
    i_fifo_empty = 1'b1;
    q.push_back(8'hA5);
    step();
    step();
    check_eq("rst_rd_en", o_rd_en, 0);
    check_eq("rst_locked", o_locked, 0);
    check_eq("rst_error", o_error, 0);
    check_eq("rst_good", good_cnt, 0);
    check_eq("rst_err", err_cnt, 0);
    reset_async = 1'b0;
    q.delete();
    step();

    // Clean stream
    push_seq(8'h01, 7);
    drain();
    check_eq("clean_locked", o_locked, 1);
    check_eq("clean_good", good_cnt, 4);
    check_eq("clean_err", err_cnt, 0);
    check_eq("clean_pulses", err_pulses, 0);

    // Single corruption while locked
    do_reset();
    q.push_back(8'h01); q.push_back(8'h02); q.push_back(8'h04); q.push_back(8'h09);
    q.push_back(8'h12); q.push_back(8'hFF); q.push_back(8'h49); q.push_back(8'h92);
    drain();
    check_eq("corr_pulses", err_pulses, 1);
    check_eq("corr_err", err_cnt, 1);
    check_eq("corr_locked", o_locked, 1);
    check_eq("corr_good", good_cnt, 4);

    // Loss of lock and relock
    do_reset();
    push_seq(8'h01, 4);
    seq_w = 8'h12;
    for (int i = 0; i < 4; i++) begin
      q.push_back(seq_w ^ 8'h80);
      seq_w = lfsr_next(seq_w);
    end
    drain();
    check_eq("loss_err", err_cnt, 4);
    check_eq("loss_pulses", err_pulses, 4);
    check_eq("loss_locked", o_locked, 0);
    push_seq(8'h01, 4);
    drain();
    check_eq("relock_locked", o_locked, 1);
    check_eq("relock_good", good_cnt, 2);

    // Empty gaps and enable low
    push_seq(8'h12, 6);
    for (int i = 0; i < 18; i++) begin
      force_empty = ((i / 3) % 2) == 1;
      step();
    end
    force_empty = 1'b0;
    i_enable = 1'b0;
    step();
    step();
    begin
      logic [15:0] snap;
      int rd_hi;
      snap = good_cnt;
      rd_hi = 0;
      for (int i = 0; i < 8; i++) begin
        i_fifo_empty = (q.size() == 0);
        #1 if (o_rd_en) rd_hi++;
        step();
      end
      check_eq("dis_rd_en", rd_hi, 0);
      check_eq("dis_good_hold", good_cnt, snap);
      check_eq("dis_locked", o_locked, 1);
    end
    i_enable = 1'b1;
    drain();
    check_eq("gap_good", good_cnt, 8);
    check_eq("gap_err", err_cnt, 4);
    check_eq("gap_pulses", err_pulses, 4);
    check_eq("gap_locked", o_locked, 1);

    // All-zero stream
    do_reset();
    for (int i = 0; i < 20; i++) q.push_back(8'h00);
    drain();
    check_eq("zero_locked", o_locked, 1);
    check_eq("zero_good", good_cnt, 17);
    check_eq("zero_err", err_cnt, 0);
    check_eq("zero_good_w4", good_w4, 15);

    // Saturation, clear, reset mid-stream
    do_reset();
    push_seq(8'h01, 33);
    drain();
    check_eq("sat_good16", good_cnt, 30);
    check_eq("sat_good_w4", good_w4, 15);
    check_eq("sat_err_w4", err_w4, 0);
    i_clr_cnt = 1'b1;
    push_seq(seq_w, 2);
    drain();
    i_clr_cnt = 1'b0;
    check_eq("clr_good16", good_cnt, 0);
    check_eq("clr_good_w4", good_w4, 0);
    check_eq("clr_locked", o_locked, 1);
    push_seq(seq_w, 12);
    repeat (4) step();
    reset_async = 1'b1;
    #1;
    check_eq("midrst_rd_en", o_rd_en, 0);
    check_eq("midrst_locked", o_locked, 0);
    check_eq("midrst_good", good_cnt, 0);
    check_eq("midrst_err", err_cnt, 0);
    step();
    step();
    check_eq("midrst_rd_en_hold", o_rd_en, 0);
    reset_async = 1'b0;
    err_pulses = 0;
    drain();
    check_eq("post_rst_locked", o_locked, 1);
    check_eq("post_rst_pulses", err_pulses, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
